// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, status flag bundle and its reset value.
package alu_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      NOT = 3'b100,
      XOR = 3'b101,
      SHL = 3'b110,
      SHR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } alu_flags_t;

   // An all-zero result register reads as zero, so the zero flag resets high.
   localparam alu_flags_t FLAGS_RST = '{carry: 1'b0, zero: 1'b1, negative: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between operand registers and the ALU.
// master drives operands and opcode; slave returns the registered result and flags.
interface alu_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       ALU_Sel;
   logic             in_valid;
   logic [WIDTH-1:0] ALU_Out;
   logic             out_valid;
   logic             carry;
   logic             zero;
   logic             negative;
   logic             overflow;

   modport master (
      output A, B, ALU_Sel, in_valid,
      input  ALU_Out, out_valid, carry, zero, negative, overflow
   );

   modport slave (
      input  A, B, ALU_Sel, in_valid,
      output ALU_Out, out_valid, carry, zero, negative, overflow
   );
endinterface

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor (a + ~b + 1 when sub), zero latency.
// No flow control; carry is carry-out on add and no-borrow on subtract.
module alu_addsub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);
   logic [WIDTH-1:0] b_eff;

   assign b_eff = sub ? ~b : b;
   assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
   // Same-sign addends whose sum flips sign; with b inverted this covers subtract too.
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu.sv
// Two-operand ALU with registered result/flags, 1-cycle latency, one op per cycle.
// No backpressure: invalid cycles hold result/flags and drop out_valid on the next edge.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);
   alu_op_e          op;
   logic [WIDTH-1:0] as_sum;
   logic             as_carry;
   logic             as_ovf;
   logic [WIDTH-1:0] res;
   alu_flags_t       flg;
   logic [WIDTH-1:0] out_r;
   alu_flags_t       flg_r;
   logic             vld_r;

   assign op = alu_op_e'(bus.ALU_Sel);

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a        (bus.A),
      .b        (bus.B),
      .sub      (op == SUB),
      .sum      (as_sum),
      .carry    (as_carry),
      .overflow (as_ovf)
   );

   always_comb begin
      res = '0;
      flg = '0;
      case (op)
         ADD, SUB: begin
            res          = as_sum;
            flg.carry    = as_carry;
            flg.overflow = as_ovf;
         end
         AND: res = bus.A & bus.B;
         OR:  res = bus.A | bus.B;
         NOT: res = ~bus.A;
         XOR: res = bus.A ^ bus.B;
         SHL: begin
            res       = {bus.A[WIDTH-2:0], 1'b0};
            flg.carry = bus.A[WIDTH-1];
         end
         SHR: begin
            res       = {1'b0, bus.A[WIDTH-1:1]};
            flg.carry = bus.A[0];
         end
      endcase
      flg.zero     = (res == '0);
      flg.negative = res[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_r <= '0;
         flg_r <= FLAGS_RST;
         vld_r <= 1'b0;
      end else begin
         vld_r <= bus.in_valid;
         if (bus.in_valid) begin
            out_r <= res;
            flg_r <= flg;
         end
      end
   end

   assign bus.ALU_Out   = out_r;
   assign bus.out_valid = vld_r;
   assign bus.carry     = flg_r.carry;
   assign bus.zero      = flg_r.zero;
   assign bus.negative  = flg_r.negative;
   assign bus.overflow  = flg_r.overflow;
endmodule

// File: tb/tb_alu.sv
// Randomised and directed checks of alu against an integer-arithmetic reference model.
module tb_alu;
   import alu_pkg::*;

   localparam int W = 4;
   // Packed observation vector: {ALU_Out, carry, zero, negative, overflow, out_valid}
   localparam logic [W+4:0] RST_VEC = {{W{1'b0}}, 5'b01000};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   bit   running = 1'b1;

   alu_if #(.WIDTH(W)) bus ();

   alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      alu_op_e      op;
      logic [W+4:0] exp;
   } vec_t;

   vec_t dir [12] = '{
      '{4'b0011, 4'b0001, ADD, {4'b0100, 5'b00001}},
      '{4'b0100, 4'b0001, SUB, {4'b0011, 5'b10001}},
      '{4'b1010, 4'b1100, AND, {4'b1000, 5'b00101}},
      '{4'b1010, 4'b1100, OR,  {4'b1110, 5'b00101}},
      '{4'b1100, 4'b0101, NOT, {4'b0011, 5'b00001}},
      '{4'b1111, 4'b0001, ADD, {4'b0000, 5'b11001}},
      '{4'b0111, 4'b0001, ADD, {4'b1000, 5'b00111}},
      '{4'b0000, 4'b0001, SUB, {4'b1111, 5'b00101}},
      '{4'b1000, 4'b0001, SUB, {4'b0111, 5'b10011}},
      '{4'b1001, 4'b0000, SHL, {4'b0010, 5'b10001}},
      '{4'b1001, 4'b0000, SHR, {4'b0100, 5'b10001}},
      '{4'b1010, 4'b1010, XOR, {4'b0000, 5'b01001}}
   };

   // Reference: operands as plain integers, signed view for overflow range checks.
   function automatic void ref_op(input int a, input int b, input int op,
                                  output int r, output bit c, output bit v);
      int m, h, sa, sb, ss;
      m  = 1 << W;
      h  = 1 << (W - 1);
      sa = (a >= h) ? a - m : a;
      sb = (b >= h) ? b - m : b;
      r  = 0;
      c  = 1'b0;
      v  = 1'b0;
      case (op)
         0: begin
            r  = (a + b) % m;
            c  = (a + b) >= m;
            ss = sa + sb;
            v  = (ss < -h) || (ss >= h);
         end
         1: begin
            r  = (a - b + m) % m;
            c  = (a >= b);
            ss = sa - sb;
            v  = (ss < -h) || (ss >= h);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = (m - 1) - a;
         5: r = a ^ b;
         6: begin r = (a * 2) % m; c = (a >= h); end
         default: begin r = a / 2; c = (a % 2) == 1; end
      endcase
   endfunction

   function automatic logic [W+4:0] exp_vec(input int a, input int b, input int op, input bit vld);
      int r;
      bit c, v;
      ref_op(a, b, op, r, c, v);
      return {W'(r), c, (r == 0), (r >= (1 << (W - 1))), v, vld};
   endfunction

   function automatic logic [W+4:0] dut_vec();
      return {bus.ALU_Out, bus.carry, bus.zero, bus.negative, bus.overflow, bus.out_valid};
   endfunction

   task automatic check(input string name, input logic [W+4:0] got, input logic [W+4:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got out/c/z/n/v/vld=%b required %b at %0t", name, got, exp, $time);
      end
   endtask

   // Model state: what the outputs must show after the latest edge or reset.
   logic [W+4:0] m_vec = RST_VEC;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         m_vec <= RST_VEC;
      else if (bus.in_valid)
         m_vec <= exp_vec(int'(bus.A), int'(bus.B), int'(bus.ALU_Sel), 1'b1);
      else
         m_vec[0] <= 1'b0;
   end

   always @(posedge clk) begin
      #1;
      if (running) check("model", dut_vec(), m_vec);
   end

   logic [W+4:0] hold_exp;

   initial begin
      bus.A        = '0;
      bus.B        = '0;
      bus.ALU_Sel  = '0;
      bus.in_valid = 1'b0;

      repeat (4) begin
         @(negedge clk);
         bus.A        = W'($urandom);
         bus.B        = W'($urandom);
         bus.ALU_Sel  = 3'($urandom);
         bus.in_valid = 1'b1;
         @(posedge clk);
         #2;
         check("reset_hold", dut_vec(), RST_VEC);
      end

      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #2;
         check("post_reset_idle", dut_vec(), RST_VEC);
      end

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus.A        = dir[i].a;
         bus.B        = dir[i].b;
         bus.ALU_Sel  = dir[i].op;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #2;
         check($sformatf("directed_%0d_%s", i, dir[i].op.name()), dut_vec(), dir[i].exp);
      end

      hold_exp = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.A        = W'($urandom);
         bus.B        = W'($urandom);
         bus.ALU_Sel  = 3'($urandom);
         bus.in_valid = (i % 2 == 0);
         if (i % 2 == 0)
            hold_exp = exp_vec(int'(bus.A), int'(bus.B), int'(bus.ALU_Sel), 1'b1);
         else
            hold_exp[0] = 1'b0;
         @(posedge clk);
         #2;
         check($sformatf("valid_gate_%0d", i), dut_vec(), hold_exp);
      end

      repeat (400) begin
         @(negedge clk);
         bus.A        = W'($urandom);
         bus.B        = W'($urandom);
         bus.ALU_Sel  = 3'($urandom);
         bus.in_valid = ($urandom_range(3) != 0);
      end

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.A        = W'($urandom);
         bus.B        = W'($urandom);
         bus.ALU_Sel  = ADD;
         bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #2;
      check("pre_async_valid", {4'b0000, dut_vec()[0]}, {4'b0000, 1'b1});
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", dut_vec(), RST_VEC);
      @(posedge clk);
      #2;
      check("async_reset_held", dut_vec(), RST_VEC);
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      running = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
